// File: rtl/ram_4x3_pkg.sv
// ram_4x3_pkg
//   Shared constants and types for the 4-word x 3-bit register-file RAM.
//   ADDR_W : address width (depth = 2**ADDR_W)
//   DATA_W : word width in bits
//   DEPTH  : number of words
//   word_t : one stored word
package ram_4x3_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

endpackage : ram_4x3_pkg

// File: rtl/ram_4x3_word.sv
// ram_4x3_word
//   One storage word: a W-bit register with asynchronous active-high clear
//   and a synchronous write enable.
//   clk : write clock (rising edge)
//   rst : asynchronous active-high clear, dominates any write
//   we  : write enable, loads d at the rising edge of clk
//   d   : write data
//   q   : stored word
module ram_4x3_word #(
  parameter int W = ram_4x3_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: non-blocking assignment for clocked state so every register
  // samples the pre-edge values regardless of evaluation order.
  // NOTE: storage is built from flops rather than an SRAM macro because the
  // whole array must clear asynchronously; a RAM macro cannot be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      // An unknown enable does not take this branch, so the word holds.
      q <= d;
    end
  end

endmodule : ram_4x3_word

// File: rtl/ram_4x3.sv
// ram_4x3
//   Four-word x three-bit RAM with synchronous write and combinational read.
//   Clk     : clock; writes happen on its rising edge
//   Reset   : asynchronous active-high reset, clears every word to 0
//   Addr    : word address shared by write and read
//   DataIn  : write data
//   Write   : 1 = store DataIn into word Addr at the rising edge of Clk
//   DataOut : combinational read of word Addr (write-through after the edge)
module ram_4x3 #(
  parameter int ADDR_W = ram_4x3_pkg::ADDR_W,
  parameter int DATA_W = ram_4x3_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Write,
  output logic [DATA_W-1:0] DataOut
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DEPTH-1:0]  word_we;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // One-hot write decode: only the addressed word can be loaded.
    assign word_we[i] = Write && (Addr == ADDR_W'(i));

    ram_4x3_word #(
      .W (DATA_W)
    ) u_word (
      .clk (Clk),
      .rst (Reset),
      .we  (word_we[i]),
      .d   (DataIn),
      .q   (word_q[i])
    );
  end

  // Every ADDR_W-bit address selects a real word, so the mux is complete.
  assign DataOut = word_q[Addr];

endmodule : ram_4x3

// File: tb/tb_ram_4x3.sv
// tb_ram_4x3
//   Directed self-checking bench for ram_4x3. A behavioural array model
//   tracks expected contents; a compare process checks DataOut against it on
//   every falling edge, and directed literal checks pin the model itself.
module tb_ram_4x3;

  logic       clk;
  logic       rst;
  logic [1:0] addr;
  logic [2:0] din;
  logic       wr;
  logic [2:0] dout;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_mem [4];

  ram_4x3 dut (
    .Clk     (clk),
    .Reset   (rst),
    .Addr    (addr),
    .DataIn  (din),
    .Write   (wr),
    .DataOut (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain array, cleared by reset, written only when
  // Write is a definite 1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_mem[i] <= 3'b000;
    end else if (wr === 1'b1) begin
      exp_mem[addr] <= din;
    end
  end

  // Per-cycle compare, sampled away from the active edge.
  always @(negedge clk) begin
    check("model_read", dout, rst ? 3'b000 : exp_mem[addr]);
  end

  // Caller is aligned 2 ns after a rising edge; returns aligned the same way.
  task automatic write_word(input logic [1:0] a, input logic [2:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    @(posedge clk);
    #2;
    wr   = 1'b0;
  endtask

  task automatic read_lit(input string name, input logic [1:0] a, input logic [2:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  initial begin
    rst  = 1'b1;
    addr = 2'd0;
    din  = 3'd0;
    wr   = 1'b0;

    // Reset held for two cycles, then every address reads zero.
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int a = 0; a < 4; a++) read_lit("reset_sweep", 2'(a), 3'b000);
    @(posedge clk);
    #2;

    // Sequential fill, then read back.
    write_word(2'd0, 3'b101);
    write_word(2'd1, 3'b010);
    write_word(2'd2, 3'b111);
    write_word(2'd3, 3'b000);
    read_lit("fill_rd0", 2'd0, 3'b101);
    read_lit("fill_rd1", 2'd1, 3'b010);
    read_lit("fill_rd2", 2'd2, 3'b111);
    read_lit("fill_rd3", 2'd3, 3'b000);
    @(posedge clk);
    #2;

    // Write-through: old word before the edge, new word right after.
    addr = 2'd1;
    din  = 3'b110;
    wr   = 1'b1;
    #1;
    check("wt_before", dout, 3'b010);
    @(posedge clk);
    #1;
    check("wt_after", dout, 3'b110);
    #1;
    wr = 1'b0;

    // Hold: Write=0 with random data must not change anything.
    addr = 2'd2;
    for (int c = 0; c < 5; c++) begin
      din = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("hold_rd2", dout, 3'b111);
      @(posedge clk);
      #2;
    end
    read_lit("hold_rd0", 2'd0, 3'b101);
    read_lit("hold_rd1", 2'd1, 3'b110);
    read_lit("hold_rd3", 2'd3, 3'b000);

    // Unknown Write is treated as no write.
    addr = 2'd0;
    din  = 3'b011;
    wr   = 1'bx;
    @(posedge clk);
    #2;
    wr = 1'b0;
    read_lit("xwrite_rd0", 2'd0, 3'b101);
    @(posedge clk);
    #2;

    // Mid-operation reset pulse between edges: immediate clear.
    addr = 2'd2;
    #1;
    rst = 1'b1;
    #1;
    check("async_clr", dout, 3'b000);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) read_lit("post_rst_sweep", 2'(a), 3'b000);
    @(posedge clk);
    #2;

    // Write edge coinciding with reset is ignored.
    rst  = 1'b1;
    addr = 2'd1;
    din  = 3'b101;
    wr   = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    wr  = 1'b0;
    read_lit("rst_blocks_wr", 2'd1, 3'b000);
    @(posedge clk);
    #2;

    // First write right after reset release, then overwrite isolation.
    write_word(2'd1, 3'b100);
    write_word(2'd2, 3'b110);
    write_word(2'd3, 3'b001);
    write_word(2'd0, 3'b011);
    read_lit("iso_rd0", 2'd0, 3'b011);
    read_lit("iso_rd1", 2'd1, 3'b100);
    read_lit("iso_rd2", 2'd2, 3'b110);
    read_lit("iso_rd3", 2'd3, 3'b001);
    @(posedge clk);
    #2;

    // Rewrite one word and confirm neighbours keep their values.
    write_word(2'd2, 3'b010);
    read_lit("rew_rd2", 2'd2, 3'b010);
    read_lit("rew_rd1", 2'd1, 3'b100);
    read_lit("rew_rd3", 2'd3, 3'b001);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_4x3
